// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: glitch-free ratio changes at period boundaries, clean run/stop.
// Optional tick output (one pulse per clk_out rising edge) enabled by CLK_DIV_CTRL_TICK_EN.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             busy
`ifdef CLK_DIV_CTRL_TICK_EN
  ,
  output logic             tick
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] div;
  } slot_t;

  localparam logic [CNT_W-1:0] DEF_A   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  slot_t            pend, pend_nxt;
  logic [CNT_W-1:0] act_div, div_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             period_end;
  logic             cfg_fire;
  logic             clk_nxt;

  assign period_end = (state != IDLE) && (cnt == act_div - ONE);
  assign cfg_fire   = cfg_valid && !pend.vld;
  assign clk_nxt    = (state != IDLE) && (cnt < (act_div >> 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = act_div;
    pend_nxt  = pend;

    // Capture only into an empty slot, so a capture and an apply never collide.
    if (cfg_fire) begin
      pend_nxt.vld = 1'b1;
      pend_nxt.div = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    end

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pend.vld) begin
          div_nxt      = pend.div;
          pend_nxt.vld = 1'b0;
        end
        if (run) state_nxt = RUN;
      end
      RUN, STOP: begin
        cnt_nxt = period_end ? '0 : cnt + ONE;
        if (period_end && pend.vld) begin
          div_nxt      = pend.div;
          pend_nxt.vld = 1'b0;
        end
        if (state == RUN) begin
          // run dropping on the last cycle of a period ends right there.
          if (!run) state_nxt = period_end ? IDLE : STOP;
        end else if (period_end) begin
          state_nxt = run ? RUN : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      act_div <= DEF_A;
      pend    <= '0;
      clk_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act_div <= div_nxt;
      pend    <= pend_nxt;
      clk_out <= clk_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign cfg_ready = !pend.vld;

`ifdef CLK_DIV_CTRL_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= clk_nxt && !clk_out;
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: per-cycle vector table plus hand-written
// stop-to-idle and mid-period reset sequences.
module tb_clk_div_ctrl;
  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             busy;
`ifdef CLK_DIV_CTRL_TICK_EN
  logic             tick;
`endif

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .busy      (busy)
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic             run;
    logic             cv;
    logic [CNT_W-1:0] cd;
    logic             clk;
    logic             bsy;
    logic             rdy;
    logic             tck;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_clk;

  // Expected tick is a rise of the expected clk_out sequence.
  task automatic push(input logic r, input logic cv, input logic [CNT_W-1:0] cd,
                      input logic c, input logic b, input logic rd);
    vec_t v;
    v.run = r; v.cv = cv; v.cd = cd; v.clk = c; v.bsy = b; v.rdy = rd;
    v.tck = c & ~prev_clk;
    prev_clk = c;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic [CNT_W-1:0] cd);
    run = r; cfg_valid = cv; cfg_div = cd;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic c, input logic b,
                     input logic rd, input logic tk);
    cmp({nm, ".clk_out"}, idx, clk_out, c);
    cmp({nm, ".busy"}, idx, busy, b);
    cmp({nm, ".cfg_ready"}, idx, cfg_ready, rd);
`ifdef CLK_DIV_CTRL_TICK_EN
    cmp({nm, ".tick"}, idx, tick, tk);
`else
    if (tk === 1'bx) $display("unexpected x tick expectation");
`endif
  endtask

  logic exp_rst[8];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, '0);
    prev_clk = 1'b0;
    #12;
    chk("reset", 0, 0, 0, 1, 0);
    rst_n = 1'b1;

    // A=4 start, first high two edges after run is raised
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1); push(1,0,0, 1,1,1); push(1,0,0, 0,1,1);
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1);
    // ratio 6 accepted mid-period, applied at period end
    push(1,1,6, 1,1,0); push(1,0,0, 0,1,0); push(1,0,0, 0,1,1);
    push(1,0,0, 1,1,1); push(1,0,0, 1,1,1); push(1,0,0, 1,1,1);
    push(1,0,0, 0,1,1); push(1,0,0, 0,1,1); push(1,0,0, 0,1,1); push(1,0,0, 1,1,1);
    // ratio 1 clamps to 2
    push(1,1,1, 1,1,0); push(1,0,0, 1,1,0); push(1,0,0, 0,1,0); push(1,0,0, 0,1,0);
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1); push(1,0,0, 0,1,1); push(1,0,0, 1,1,1);
    push(1,0,0, 0,1,1);
    // ratio 5: 2 high / 3 low
    push(1,1,5, 1,1,0); push(1,0,0, 0,1,1); push(1,0,0, 1,1,1); push(1,0,0, 1,1,1);
    push(1,0,0, 0,1,1); push(1,0,0, 0,1,1);
    // ratio 3 offered on the period-end cycle: full 5-period before it applies
    push(1,1,3, 0,1,0); push(1,0,0, 1,1,0); push(1,0,0, 1,1,0); push(1,0,0, 0,1,0);
    push(1,0,0, 0,1,0); push(1,0,0, 0,1,1);
    push(1,0,0, 1,1,1); push(1,0,0, 0,1,1); push(1,0,0, 0,1,1); push(1,0,0, 1,1,1);
    // stop with A=3
    push(0,0,0, 0,1,1); push(0,0,0, 0,0,1); push(0,0,0, 0,0,1);
    // ratio 8 loaded in IDLE
    push(0,1,8, 0,0,0); push(0,0,0, 0,0,1);
    // run, drop at cnt=1: period completes 4 high / 4 low then IDLE
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1); push(0,0,0, 1,1,1); push(0,0,0, 1,1,1);
    push(0,0,0, 1,1,1); push(0,0,0, 0,1,1); push(0,0,0, 0,1,1); push(0,0,0, 0,1,1);
    push(0,0,0, 0,0,1); push(0,0,0, 0,0,1);
    // run re-raised inside the stopping period: no gap
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1); push(0,0,0, 1,1,1); push(1,0,0, 1,1,1);
    push(1,0,0, 1,1,1); push(1,0,0, 0,1,1); push(1,0,0, 0,1,1); push(1,0,0, 0,1,1);
    push(1,0,0, 0,1,1); push(1,0,0, 1,1,1);

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].cv, tbl[i].cd);
      step();
      chk("vec", i, tbl[i].clk, tbl[i].bsy, tbl[i].rdy, tbl[i].tck);
    end

    // drain to IDLE, bounded
    drive(0, 0, '0);
    for (int k = 0; k < 20 && busy; k++) step();
    cmp("drain.busy", 0, busy, 1'b0);

    // load A=6 in IDLE, run to cnt=2 with P holding 3
    drive(0, 1, 6); step(); cmp("ld6.cfg_ready", 0, cfg_ready, 1'b0);
    drive(0, 0, 0); step(); cmp("ld6.cfg_ready", 1, cfg_ready, 1'b1);
    drive(1, 0, 0); step();
    drive(1, 1, 3); step();
    drive(1, 0, 0); step();
    cmp("pre_rst.clk_out", 0, clk_out, 1'b1);
    cmp("pre_rst.cfg_ready", 0, cfg_ready, 1'b0);

    #1 rst_n = 1'b0;
    #1 chk("mid_rst", 0, 0, 0, 1, 0);
    #2 rst_n = 1'b1;

    // after release, default A=4 and no leftover pending ratio
    exp_rst = '{0, 1, 1, 0, 0, 1, 1, 0};
    prev_clk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst", i, exp_rst[i], 1'b1, 1'b1, exp_rst[i] & ~prev_clk);
      prev_clk = exp_rst[i];
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide-ratio and period counter.
REQ-002 Parameter DEF_DIV, default 4: active divide ratio loaded at reset.
REQ-003 clk_in  input  1: single block clock; all logic on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 run  input  1: level request to generate clk_out.
REQ-006 cfg_valid  input  1: new divide ratio offered on cfg_div.
REQ-007 cfg_div  input  CNT_W: requested ratio N; output period N clk_in cycles.
REQ-008 cfg_ready  output  1: pending-ratio slot empty; cfg accepted when cfg_valid&&cfg_ready.
REQ-009 clk_out  output  1: registered divided clock.
REQ-010 busy  output  1: high in RUN or STOP state.
REQ-011 tick  output  1: present only per REQ-027.

Function
REQ-012 Block SHALL hold an active ratio A and a one-entry pending slot P with valid flag; cfg_ready SHALL equal !P.valid.
REQ-013 Ratios below 2 SHALL be clamped to 2 when captured into P; ratio 0 and 1 never reach A.
REQ-014 States IDLE, RUN, STOP; IDLE->RUN when run=1; RUN->STOP when run=0; STOP->IDLE or STOP->RUN only at period end (cnt==A-1), chosen by run at that cycle.
REQ-015 Period counter cnt SHALL count 0..A-1 in RUN/STOP and wrap to 0; held at 0 in IDLE.
REQ-016 clk_out SHALL be 1 while cnt < A>>1 and 0 otherwise, registered (1 cycle after cnt); odd A gives shorter high phase.
REQ-017 First clk_out high cycle SHALL appear exactly 2 clk_in cycles after the run rising edge sampled in IDLE.
REQ-018 P SHALL be applied to A only at period end (cnt==A-1) in RUN/STOP, or on the first cycle in IDLE; P.valid cleared the same cycle.
REQ-019 A cfg handshake in the same cycle as a period end SHALL be captured into P and applied at the following period end, never mid-period.
REQ-020 clk_out SHALL never produce a high or low phase shorter than min(oldA,newA)>>1 cycles across a ratio change or stop (glitch-free).
REQ-021 run dropping and rising within one period SHALL not truncate the period: STOP returns to RUN at period end with no gap.
REQ-022 In IDLE clk_out SHALL be 0 and busy 0.

Reset
REQ-023 On rst_n low, asynchronously: state IDLE, cnt 0, clk_out 0, busy 0, tick 0, P.valid 0, cfg_ready 1, A=DEF_DIV.
REQ-024 Reset mid-period SHALL force clk_out 0 immediately and discard P.
REQ-025 After rst_n release, first run sampling SHALL occur at the first clk_in rising edge.

Configuration
REQ-026 Macro CLK_DIV_CTRL_TICK_EN SHALL select tick generation.
REQ-027 With CLK_DIV_CTRL_TICK_EN defined: tick port exists, one-cycle pulse coincident with each clk_out 0->1 transition; undefined: port and logic absent, all other behaviour identical.

Verification
REQ-028 Reset, run=1, A=4 -> clk_out 1,1,0,0 repeating, first high 2 cycles after run; busy=1.
REQ-029 Running A=4, cfg_div=6 accepted mid-period -> current period completes at 4, next periods 3 high/3 low; cfg_ready low until applied.
REQ-030 cfg_div=1 accepted -> ratio behaves as 2 (clk_out toggles every cycle); cfg_div=5 -> 2 high/3 low.
REQ-031 run=0 at cnt=1 with A=8 -> period completes (4 high, 4 low), then IDLE, clk_out 0, busy 0; run pulse re-raised before period end -> no gap.
REQ-032 rst_n low at cnt=2 of A=6 with P valid -> clk_out 0 immediately, after release A=4, cfg_ready=1.
REQ-033 With CLK_DIV_CTRL_TICK_EN, A=3 -> tick high exactly one cycle every 3, aligned with clk_out rise.
